alu_sequencer: RTL and testbench

//  Control side of the accumulator datapath: accepts one operation request at a time,

---
 rtl/alu_sequencer_pkg.sv | 24 ++
 rtl/alu_sequencer_decode.sv | 40 ++++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode values, ALU ctrl encodings and sequencer enums for the accumulator datapath.
// The instruction decoder imports this package so both sides agree on the encodings.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd7;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_NOT0 = 3'b110;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
  typedef enum logic [1:0] {CIN_ZERO, CIN_ONE, CIN_FLAG} cin_sel_t;
  typedef enum logic [1:0] {SRC_ALU, SRC_OPERAND, SRC_ZERO} acc_src_t;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational decode of the latched opcode into ALU controls and write-back enables.
import alu_sequencer_pkg::*;

module alu_op_decode (
  input  logic [3:0] op,
  output logic [2:0] alu_ctrl,
  output cin_sel_t   cin_sel,
  output logic       acc_we,
  output acc_src_t   acc_src,
  output logic       cv_we
);

  // Opcodes 8-15 fall to the default and leave ACC and all flags untouched.
  always_comb begin
    alu_ctrl = ALU_ADD;
    cin_sel  = CIN_ZERO;
    acc_we   = 1'b1;
    acc_src  = SRC_ALU;
    cv_we    = 1'b0;
    case (op)
      OP_LOAD: acc_src = SRC_OPERAND;
      OP_ADD:  cv_we = 1'b1;
      OP_ADC: begin
        cin_sel = CIN_FLAG;
        cv_we   = 1'b1;
      end
      OP_SUB: begin
        alu_ctrl = ALU_SUB;
        cin_sel  = CIN_ONE;
        cv_we    = 1'b1;
      end
      OP_OR:   alu_ctrl = ALU_OR;
      OP_AND:  alu_ctrl = ALU_AND;
      OP_NOT:  alu_ctrl = ALU_NOT0;
      OP_CLR:  acc_src = SRC_ZERO;
      default: acc_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator sequencer: accepts one request, drives the external ALU from registers,
// and writes the result back to ACC and the C/V/Z flags three cycles per operation.
import alu_sequencer_pkg::*;

module alu_sequencer #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [3:0]   op_code,
  input  logic [n-1:0] operand,
  output logic [n-1:0] alu_in0,
  output logic [n-1:0] alu_in1,
  output logic         alu_c_in,
  output logic [2:0]   alu_ctrl,
  input  logic [n-1:0] alu_out,
  input  logic         alu_c_out,
  input  logic         alu_v,
  output logic [n-1:0] acc,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         done
);

  state_t       state;
  logic [3:0]   op_reg;
  logic [n-1:0] opnd_reg;
  logic [n-1:0] res_reg;
  logic         c_cap;
  logic         v_cap;
  logic [n-1:0] acc_next;
  cin_sel_t     cin_sel;
  acc_src_t     acc_src;
  logic         acc_we;
  logic         cv_we;

  alu_op_decode u_decode (
    .op       (op_reg),
    .alu_ctrl (alu_ctrl),
    .cin_sel  (cin_sel),
    .acc_we   (acc_we),
    .acc_src  (acc_src),
    .cv_we    (cv_we)
  );

  assign alu_in0 = acc;
  assign alu_in1 = opnd_reg;

  // ADC reads the live C flag, so a back-to-back ADC sees the previous write-back.
  always_comb begin
    alu_c_in = 1'b0;
    case (cin_sel)
      CIN_ONE:  alu_c_in = 1'b1;
      CIN_FLAG: alu_c_in = flag_c;
      default:  alu_c_in = 1'b0;
    endcase
  end

  always_comb begin
    acc_next = res_reg;
    case (acc_src)
      SRC_OPERAND: acc_next = opnd_reg;
      SRC_ZERO:    acc_next = '0;
      default:     acc_next = res_reg;
    endcase
  end

  // op_ready and done are registered so the decoder sees glitch-free handshakes;
  // done rises together with the new ACC/flag values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_reg   <= '0;
      opnd_reg <= '0;
      res_reg  <= '0;
      c_cap    <= 1'b0;
      v_cap    <= 1'b0;
      acc      <= '0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_z   <= 1'b1;
      done     <= 1'b0;
      op_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_ready && op_valid) begin
            op_reg   <= op_code;
            opnd_reg <= operand;
            op_ready <= 1'b0;
            state    <= ST_EXEC;
          end else begin
            op_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          res_reg <= alu_out;
          c_cap   <= alu_c_out;
          v_cap   <= alu_v;
          state   <= ST_WB;
        end
        ST_WB: begin
          done <= 1'b1;
          if (acc_we) begin
            acc    <= acc_next;
            flag_z <= (acc_next == '0);
          end
          if (cv_we) begin
            flag_c <= c_cap;
            flag_v <= v_cap;
          end
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          op_ready <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU on the datapath side.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_code = '0;
  logic [7:0] operand = '0;
  logic [7:0] alu_in0;
  logic [7:0] alu_in1;
  logic       alu_c_in;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_out;
  logic       alu_c_out;
  logic       alu_v;
  logic [7:0] acc;
  logic       flag_c;
  logic       flag_v;
  logic       flag_z;
  logic       done;

  int checks = 0;
  int fails = 0;
  int done_count = 0;
  int accept_count = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] opnd;
    logic [7:0] exp_acc;
    logic       exp_c;
    logic       exp_v;
    logic       exp_z;
  } vec_t;

  vec_t vecs[15];

  alu_sequencer #(.n(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .operand   (operand),
    .alu_in0   (alu_in0),
    .alu_in1   (alu_in1),
    .alu_c_in  (alu_c_in),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_c_out (alu_c_out),
    .alu_v     (alu_v),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference ALU: subtraction is in0 + ~in1 + c_in, overflow from operand/result signs.
  logic [8:0] sum;
  logic [7:0] b_eff;
  always_comb begin
    sum       = '0;
    b_eff     = alu_in1;
    alu_out   = '0;
    alu_c_out = 1'b0;
    alu_v     = 1'b0;
    case (alu_ctrl)
      3'b000, 3'b001: begin
        b_eff     = (alu_ctrl == 3'b001) ? ~alu_in1 : alu_in1;
        sum       = {1'b0, alu_in0} + {1'b0, b_eff} + {8'd0, alu_c_in};
        alu_out   = sum[7:0];
        alu_c_out = sum[8];
        alu_v     = (alu_in0[7] == b_eff[7]) && (sum[7] != alu_in0[7]);
      end
      3'b010:  alu_out = alu_in0 | alu_in1;
      3'b100:  alu_out = alu_in0 & alu_in1;
      3'b110:  alu_out = ~alu_in0;
      default: alu_out = '0;
    endcase
  end

  always @(posedge clk) begin
    if (done) done_count++;
    if (op_valid && op_ready) accept_count++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!op_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check_output("ready_wait", {31'd0, op_ready}, 32'd1);
  endtask

  // Issue one request and check done timing plus the written-back state.
  task automatic apply_stimulus(input string tag, input logic [3:0] op, input logic [7:0] opnd,
                                input logic [7:0] e_acc, input logic e_c, input logic e_v, input logic e_z);
    wait_ready();
    op_code  = op;
    operand  = opnd;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    check_output({tag, "_done_k"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_output({tag, "_done_k1"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_output({tag, "_done_k2"}, {31'd0, done}, 32'd1);
    check_output({tag, "_acc"}, {24'd0, acc}, {24'd0, e_acc});
    check_output({tag, "_c"}, {31'd0, flag_c}, {31'd0, e_c});
    check_output({tag, "_v"}, {31'd0, flag_v}, {31'd0, e_v});
    check_output({tag, "_z"}, {31'd0, flag_z}, {31'd0, e_z});
  endtask

  initial begin
    int acc_before;
    int done_before;

    vecs[0]  = '{4'd0, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd1, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'd1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{4'd2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd0, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd3, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4'd3, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd1, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'd5, 8'h3C, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'd4, 8'h0F, 8'h1F, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'd6, 8'h00, 8'hE0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd7, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{4'd9, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1};

    $display("[TB] reset checks");
    repeat (2) @(negedge clk);
    check_output("rst_ready", {31'd0, op_ready}, 32'd0);
    check_output("rst_acc", {24'd0, acc}, 32'd0);
    check_output("rst_c", {31'd0, flag_c}, 32'd0);
    check_output("rst_v", {31'd0, flag_v}, 32'd0);
    check_output("rst_z", {31'd0, flag_z}, 32'd1);
    check_output("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", {31'd0, op_ready}, 32'd1);

    $display("[TB] vector table");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].opnd,
                     vecs[i].exp_acc, vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_z);
    end

    $display("[TB] held request accepted once");
    wait_ready();
    acc_before = accept_count;
    op_code  = 4'd0;
    operand  = 8'h33;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_output("hold_done", {31'd0, done}, 32'd1);
    op_valid = 1'b0;
    @(negedge clk);
    check_output("hold_accepts", accept_count - acc_before, 32'd1);
    check_output("hold_acc", {24'd0, acc}, 32'h33);

    $display("[TB] reset during EXEC");
    wait_ready();
    done_before = done_count;
    op_code  = 4'd1;
    operand  = 8'h01;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("abort_acc", {24'd0, acc}, 32'd0);
    check_output("abort_z", {31'd0, flag_z}, 32'd1);
    check_output("abort_ready", {31'd0, op_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("abort_no_done", done_count - done_before, 32'd0);
    check_output("abort_acc_after", {24'd0, acc}, 32'd0);

    $display("[TB] no-op leaves state");
    apply_stimulus("reload", 4'd0, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0);
    apply_stimulus("noop9", 4'd9, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
